// File: rtl/hazard_ctrl_pkg.sv
// +----------------------------------------------------------------------------+
// | hazard_ctrl_pkg : shared constants and helpers for the hazard controller     |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
`default_nettype none

package hazard_ctrl_pkg;

  localparam logic [5:0] c_op_special = 6'h00;
  localparam logic [5:0] c_fn_mfhi    = 6'h10;
  localparam logic [5:0] c_fn_mthi    = 6'h11;
  localparam logic [5:0] c_fn_mflo    = 6'h12;
  localparam logic [5:0] c_fn_mtlo    = 6'h13;
  localparam logic [5:0] c_fn_mult    = 6'h18;
  localparam logic [5:0] c_fn_multu   = 6'h19;
  localparam logic [5:0] c_fn_div     = 6'h1a;
  localparam logic [5:0] c_fn_divu    = 6'h1b;

  localparam logic [4:0] c_reg_zero   = 5'd0;

  localparam int c_mult_cycles_dflt = 5;
  localparam int c_div_cycles_dflt  = 10;

  // True when a source operand actually read by D names dst ($0 never matches).
  function automatic logic src_match(
    input logic       use_rs,
    input logic [4:0] rs,
    input logic       use_rt,
    input logic [4:0] rt,
    input logic [4:0] dst
  );
    return (use_rs && (rs != c_reg_zero) && (rs == dst)) ||
           (use_rt && (rt != c_reg_zero) && (rt == dst));
  endfunction

endpackage

`default_nettype wire

// File: rtl/md_busy_timer.sv
// +----------------------------------------------------------------------------+
// | md_busy_timer : mult/div busy countdown, loaded when an operation issues     |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
`default_nettype none

module md_busy_timer #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10,
  parameter int CNT_W       = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic is_div,
  output logic busy
);

  logic [CNT_W-1:0] r_count;

  // A start arriving while the count is running is ignored on purpose.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count <= '0;
    end else if (start && (r_count == '0)) begin
      r_count <= is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
    end else if (r_count != '0) begin
      r_count <= r_count - CNT_W'(1);
    end
  end

  assign busy = (r_count != '0);

endmodule

`default_nettype wire

// File: rtl/hazard_ctrl.sv
// +----------------------------------------------------------------------------+
// | hazard_ctrl : five-stage pipeline stall/flush/forward control + perf counts  |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
`default_nettype none

module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int MULT_CYCLES = c_mult_cycles_dflt,
  parameter int DIV_CYCLES  = c_div_cycles_dflt,
  parameter int CNT_W       = 4,
  parameter int PERF_W      = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [4:0]        RsD,
  input  logic [4:0]        RtD,
  input  logic              UseRsD,
  input  logic              UseRtD,
  input  logic              BranchD,
  input  logic              BranchTakenD,
  input  logic              MdUseD,
  input  logic [4:0]        WriteRegE,
  input  logic              RegWriteE,
  input  logic              MemtoRegE,
  input  logic [4:0]        WriteRegM,
  input  logic              RegWriteM,
  input  logic              MemtoRegM,
  input  logic              MdStartE,
  input  logic              MdIsDivE,
  input  logic              IReady,
  output logic              StallF,
  output logic              StallD,
  output logic              FlushD,
  output logic              FlushE,
  output logic              ForwardAD,
  output logic              ForwardBD,
  output logic              MdBusy,
  output logic [PERF_W-1:0] StallCnt,
  output logic [PERF_W-1:0] FlushCnt
);

  logic w_match_e;
  logic w_match_m;
  logic w_lwstall;
  logic w_brstall;
  logic w_mdstall;
  logic w_dstall;

  logic [PERF_W-1:0] r_stall_cnt;
  logic [PERF_W-1:0] r_flush_cnt;

  md_busy_timer #(
    .MULT_CYCLES (MULT_CYCLES),
    .DIV_CYCLES  (DIV_CYCLES),
    .CNT_W       (CNT_W)
  ) u_md_busy_timer (
    .clk    (clk),
    .reset  (reset),
    .start  (MdStartE),
    .is_div (MdIsDivE),
    .busy   (MdBusy)
  );

  assign w_match_e = src_match(UseRsD, RsD, UseRtD, RtD, WriteRegE);
  assign w_match_m = src_match(UseRsD, RsD, UseRtD, RtD, WriteRegM);

  assign w_lwstall = MemtoRegE & RegWriteE & w_match_e;
  assign w_brstall = BranchD & ((RegWriteE & w_match_e) | (MemtoRegM & w_match_m));
  assign w_mdstall = MdUseD & (MdBusy | MdStartE);
  assign w_dstall  = w_lwstall | w_brstall | w_mdstall;

  // A D-stage stall wins over a redirect: branch operands are not valid yet.
  always_comb begin
    StallF = 1'b0;
    StallD = 1'b0;
    FlushD = 1'b0;
    FlushE = 1'b0;
    if (w_dstall) begin
      StallF = 1'b1;
      StallD = 1'b1;
      FlushE = 1'b1;
    end else if (!IReady) begin
      StallF = 1'b1;
      FlushD = 1'b1;
    end else if (BranchTakenD) begin
      FlushD = 1'b1;
    end
  end

  assign ForwardAD = (RsD != c_reg_zero) & (RsD == WriteRegM) & RegWriteM & ~MemtoRegM;
  assign ForwardBD = (RtD != c_reg_zero) & (RtD == WriteRegM) & RegWriteM & ~MemtoRegM;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (StallD) r_stall_cnt <= r_stall_cnt + PERF_W'(1);
      if (FlushD) r_flush_cnt <= r_flush_cnt + PERF_W'(1);
    end
  end

  assign StallCnt = r_stall_cnt;
  assign FlushCnt = r_flush_cnt;

endmodule

`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
// +----------------------------------------------------------------------------+
// | tb_hazard_ctrl : directed self-checking bench for hazard_ctrl                |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_hazard_ctrl;

  logic        clk;
  logic        reset;
  logic [4:0]  RsD, RtD, WriteRegE, WriteRegM;
  logic        UseRsD, UseRtD, BranchD, BranchTakenD, MdUseD;
  logic        RegWriteE, MemtoRegE, RegWriteM, MemtoRegM;
  logic        MdStartE, MdIsDivE, IReady;
  logic        StallF, StallD, FlushD, FlushE, ForwardAD, ForwardBD, MdBusy;
  logic [31:0] StallCnt, FlushCnt;

  int total = 0;
  int bad   = 0;

  hazard_ctrl #(
    .MULT_CYCLES (5),
    .DIV_CYCLES  (10),
    .CNT_W       (4),
    .PERF_W      (32)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .RsD          (RsD),
    .RtD          (RtD),
    .UseRsD       (UseRsD),
    .UseRtD       (UseRtD),
    .BranchD      (BranchD),
    .BranchTakenD (BranchTakenD),
    .MdUseD       (MdUseD),
    .WriteRegE    (WriteRegE),
    .RegWriteE    (RegWriteE),
    .MemtoRegE    (MemtoRegE),
    .WriteRegM    (WriteRegM),
    .RegWriteM    (RegWriteM),
    .MemtoRegM    (MemtoRegM),
    .MdStartE     (MdStartE),
    .MdIsDivE     (MdIsDivE),
    .IReady       (IReady),
    .StallF       (StallF),
    .StallD       (StallD),
    .FlushD       (FlushD),
    .FlushE       (FlushE),
    .ForwardAD    (ForwardAD),
    .ForwardBD    (ForwardBD),
    .MdBusy       (MdBusy),
    .StallCnt     (StallCnt),
    .FlushCnt     (FlushCnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // {StallF, StallD, FlushD, FlushE}
  function automatic logic [31:0] ctl();
    return {28'd0, StallF, StallD, FlushD, FlushE};
  endfunction

  task automatic clr();
    RsD = 0; RtD = 0; WriteRegE = 0; WriteRegM = 0;
    UseRsD = 0; UseRtD = 0; BranchD = 0; BranchTakenD = 0; MdUseD = 0;
    RegWriteE = 0; MemtoRegE = 0; RegWriteM = 0; MemtoRegM = 0;
    MdStartE = 0; MdIsDivE = 0; IReady = 1;
  endtask

  // Every mult/div issue must find the unit idle.
  always @(negedge clk) begin
    #2;
    if (reset && MdStartE) chk("md_start_busy", {31'd0, MdBusy}, 32'd0);
  end

  initial begin
    int n;
    reset = 1'b0;
    clr();
    #12;
    chk("reset_ctl", {25'd0, StallF, StallD, FlushD, FlushE, ForwardAD, ForwardBD, MdBusy}, 32'd0);
    chk("reset_stallcnt", StallCnt, 32'd0);
    chk("reset_flushcnt", FlushCnt, 32'd0);
    @(negedge clk); reset = 1'b1;

    // load-use
    @(negedge clk);
    MemtoRegE = 1; RegWriteE = 1; WriteRegE = 8; UseRsD = 1; RsD = 8;
    #1 chk("lw_stall", ctl(), 32'hd);
    @(negedge clk);
    MemtoRegE = 0; RegWriteE = 0; WriteRegE = 0;
    WriteRegM = 8; RegWriteM = 1; MemtoRegM = 1;
    #1 chk("lw_after", ctl(), 32'h0);
    chk("lw_nofwd", {31'd0, ForwardAD}, 32'd0);
    chk("lw_stallcnt", StallCnt, 32'd1);

    // branch on ALU result in E, then forwarded from M
    @(negedge clk); clr();
    BranchD = 1; UseRsD = 1; RsD = 9; RegWriteE = 1; WriteRegE = 9;
    #1 chk("br_stall", ctl(), 32'hd);
    @(negedge clk);
    RegWriteE = 0; WriteRegE = 0; WriteRegM = 9; RegWriteM = 1; BranchTakenD = 1;
    #1 chk("br_taken", ctl(), 32'h2);
    chk("br_fwdA", {31'd0, ForwardAD}, 32'd1);
    chk("br_fwdB", {31'd0, ForwardBD}, 32'd0);
    chk("br_stallcnt", StallCnt, 32'd2);

    // branch on load in M; the redirect must be ignored while stalled
    @(negedge clk); clr();
    BranchD = 1; BranchTakenD = 1; UseRtD = 1; RtD = 10;
    MemtoRegM = 1; RegWriteM = 1; WriteRegM = 10;
    #1 chk("brm_stall", ctl(), 32'hd);
    chk("brm_nofwd", {31'd0, ForwardBD}, 32'd0);
    chk("brm_flushcnt", FlushCnt, 32'd1);

    // instruction memory wait states
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); clr(); IReady = 0;
      #1 chk("iwait_ctl", ctl(), 32'ha);
    end
    @(negedge clk);
    MemtoRegE = 1; RegWriteE = 1; WriteRegE = 4; UseRtD = 1; RtD = 4;
    #1 chk("iwait_lw_dom", ctl(), 32'hd);
    chk("iwait_flushcnt", FlushCnt, 32'd4);
    chk("iwait_stallcnt", StallCnt, 32'd3);

    // register zero never hazards or forwards
    @(negedge clk); clr();
    MemtoRegE = 1; RegWriteE = 1; WriteRegE = 0; UseRsD = 1; RsD = 0; BranchD = 1;
    RegWriteM = 1; WriteRegM = 0;
    #1 chk("r0_ctl", ctl(), 32'h0);
    chk("r0_fwd", {30'd0, ForwardAD, ForwardBD}, 32'd0);
    chk("r0_stallcnt", StallCnt, 32'd4);

    // divide with mflo waiting in D
    @(negedge clk); clr();
    MdUseD = 1; MdStartE = 1; MdIsDivE = 1;
    #1 chk("div_issue", ctl(), 32'hd);
    chk("div_issue_busy", {31'd0, MdBusy}, 32'd0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); MdStartE = 0; MdIsDivE = 0;
      #1 chk("div_busy", {30'd0, MdBusy, StallD}, 32'd3);
    end
    @(negedge clk);
    #1 chk("div_done", {27'd0, StallF, StallD, FlushD, FlushE, MdBusy}, 32'd0);
    chk("div_stallcnt", StallCnt, 32'd15);

    // mult interrupted by reset
    @(negedge clk); clr();
    MdStartE = 1;
    @(negedge clk); MdStartE = 0;
    @(negedge clk);
    #1 chk("mult_busy", {31'd0, MdBusy}, 32'd1);
    #2 reset = 1'b0;
    #1 chk("rst_busy", {31'd0, MdBusy}, 32'd0);
    chk("rst_stallcnt", StallCnt, 32'd0);
    chk("rst_flushcnt", FlushCnt, 32'd0);
    @(negedge clk); reset = 1'b1;
    #1 chk("rst_after", {27'd0, StallF, StallD, FlushD, FlushE, MdBusy}, 32'd0);

    // full mult length
    @(negedge clk); MdStartE = 1;
    @(negedge clk); MdStartE = 0;
    n = 0;
    #1;
    while (MdBusy && n < 20) begin
      n++;
      @(negedge clk);
      #1;
    end
    chk("mult_len", n, 32'd5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
